// File: rtl/demux1_2_stream.sv
// Registered 1:2 stream demux with a small FIFO per output.
// Define DEMUX_STREAM_CNT_EN to add the cnt0/cnt1 pop counters.
module demux1_2_stream #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic             out0_valid,
  input  logic             out0_ready,
  output logic [WIDTH-1:0] out0_data,
  output logic             out1_valid,
  input  logic             out1_ready,
  output logic [WIDTH-1:0] out1_data
`ifdef DEMUX_STREAM_CNT_EN
  ,
  output logic [15:0]      cnt0,
  output logic [15:0]      cnt1
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [1:0]       full;
  logic [1:0]       empty;
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       rdy;
  logic [WIDTH-1:0] head [2];

  assign rdy      = {out1_ready, out0_ready};
  assign in_ready = !rst && (in_sel ? !full[1] : !full[0]);
  assign push     = {in_valid && in_ready && in_sel,
                     in_valid && in_ready && !in_sel};
  assign pop      = ~empty & rdy & {2{!rst}};

  for (genvar g = 0; g < 2; g++) begin : g_fifo
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic [AW:0]      cnt;
    logic [WIDTH-1:0] last;

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        wptr <= '0;
        rptr <= '0;
        cnt  <= '0;
        last <= '0;
      end else begin
        if (push[g]) begin
          mem[wptr] <= in_data;
          wptr      <= wptr + 1'b1;
        end
        if (pop[g]) rptr <= rptr + 1'b1;
        if (push[g] && !pop[g]) cnt <= cnt + 1'b1;
        else if (pop[g] && !push[g]) cnt <= cnt - 1'b1;
        // Remember the head so an emptied FIFO keeps showing it.
        if (!empty[g]) last <= mem[rptr];
      end
    end

    assign full[g]  = (cnt == FULL_CNT);
    assign empty[g] = (cnt == '0);
    assign head[g]  = empty[g] ? last : mem[rptr];
  end

  assign out0_valid = !empty[0];
  assign out1_valid = !empty[1];
  assign out0_data  = head[0];
  assign out1_data  = head[1];

`ifdef DEMUX_STREAM_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (pop[0]) cnt0 <= cnt0 + 16'd1;
      if (pop[1]) cnt1 <= cnt1 + 16'd1;
    end
  end
`endif

endmodule

// File: doc/demux1_2_stream.md
Name: demux1_2_stream

Overview:
- Registered 1-to-2 stream demultiplexer. It is the splitting counterpart of the 2:1 byte mux in the datapath.
- Accepts one valid/ready input stream and steers each beat to output 0 or output 1 according to a per-beat select bit.
- Each output has a small FIFO, so a stalled output does not block beats destined for the other output once they are accepted.
- Sits between a single producer (e.g. decode/writeback staging) and two consumers.

Parameters:
- WIDTH, 8, data width in bits for the input and both outputs.
- DEPTH, 2, entries per output FIFO; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- in_valid  input  1  input beat valid
- in_ready  output  1  input beat accepted this cycle when high together with in_valid
- in_data  input  WIDTH  input beat data
- in_sel  input  1  destination of the beat: 0 selects out0, 1 selects out1
- out0_valid  output  1  out0 FIFO non-empty
- out0_ready  input  1  out0 consumer ready
- out0_data  output  WIDTH  head entry of the out0 FIFO
- out1_valid  output  1  out1 FIFO non-empty
- out1_ready  input  1  out1 consumer ready
- out1_data  output  WIDTH  head entry of the out1 FIFO

Behaviour:
- Reset: rst is sampled on the rising clk edge only.
  - Both FIFOs are emptied; pointers and occupancy counts are set to 0.
  - out0_valid and out1_valid are 0; out0_data and out1_data are 0; all storage is cleared to 0.
  - in_ready goes low for the cycle in which rst is high.
- Reset mid-operation: buffered beats are discarded. No beat is accepted or emitted on a clock edge where rst=1.
- Ready:
  - in_ready = !full0 when in_sel=0, and !full1 when in_sel=1.
  - in_ready is a combinational function of in_sel and registered state only; it never depends on outN_ready.
- Push: in_valid && in_ready at a clock edge writes in_data into the FIFO selected by in_sel.
- Pop: outN_valid && outN_ready at a clock edge removes the head of FIFO N.
- Latency: a beat accepted at edge k is visible on outN_valid/outN_data after edge k, i.e. one cycle. There is no combinational input-to-output path.
- Ordering:
  - Beats to the same output leave in acceptance order.
  - No ordering is enforced between out0 and out1.
- Input stability: the producer holds in_data and in_sel stable while in_valid=1 and in_ready=0. The block does not latch them early.
- Full FIFO: in_ready stays 0 for that destination even if a pop occurs on the same edge; there is no push-through on full. Push and pop on the same edge of a non-full, non-empty FIFO leaves the count unchanged.
- Empty FIFO: outN_valid=0, and outN_data holds its last head value, or 0 after reset. A pop request (outN_ready=1) on an empty FIFO is ignored.
- Pointer wrap: read and write pointers are log2(DEPTH) bits and wrap naturally. Occupancy is a (log2(DEPTH)+1)-bit count ranging 0..DEPTH.
- Independence: out0 and out1 pop independently on the same edge. A full out0 never blocks a beat with in_sel=1.

Optional Feature:
- Macro: DEMUX_STREAM_CNT_EN.
- Defined: adds outputs cnt0 and cnt1, each 16 bits.
  - cntN increments by 1 on every pop from FIFO N.
  - The counters wrap from 16'hFFFF to 0 and reset to 0 on rst.
  - They have no effect on the handshake.
- Undefined: the cnt0/cnt1 ports and their logic do not exist; all other behaviour is identical.

Test Plan:
1. Reset: hold rst=1 for 3 cycles with in_valid=1 -> out0_valid=out1_valid=0, out0_data=out1_data=0, in_ready=0, no beat stored.
2. Steering: with out0_ready=out1_ready=1, push 8'hA5 sel=0 then 8'h3C sel=1 -> out0 shows A5 one cycle after its accept and out1 shows 3C one cycle after its accept; each valid lasts 1 cycle.
3. Backpressure: hold out0_ready=0 and push 8'h01, 8'h02 (sel=0) -> in_ready goes 0 for sel=0 after the 2nd push. A sel=1 beat 8'hFF is still accepted and appears on out1. Releasing out0_ready then yields 01 followed by 02.
4. Full with simultaneous pop: fill out0 (DEPTH=2), then assert out0_ready with in_valid=1, sel=0 -> the pop occurs but the push is not accepted that edge. It is accepted on the next edge, and the count never exceeds 2.
5. Mid-operation reset: out1 holds 2 beats and rst is pulsed for 1 cycle -> out1_valid=0 on the next cycle and the old beats never appear.
6. Counter wrap (DEMUX_STREAM_CNT_EN only): perform 65537 pops on out0 -> cnt0 reads 16'h0001 and cnt1 stays 0. Repeat the run with the macro undefined -> identical out* traces.
